sdram_bist_master: RTL

//  Built-in self-test traffic generator placed directly upstream of the SDRAM controller.
//  On a start pulse it performs two passes over a configurable word range:
//    - a write pass that writes a deterministic pattern;
//    - a read pass that reads every word back.

---
 rtl/sdram_bist_master_if.sv | 23 ++
 rtl/sdram_bist_master.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/sdram_bist_master_if.sv
// Request/read-return bus between the BIST traffic generator and the SDRAM controller.
interface sdram_bist_master_if #(
  parameter int ADDR_W = 25,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, rd_valid, rd_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/sdram_bist_master.sv
// SDRAM BIST traffic generator: writes a seeded pattern over a word range,
// reads it back with bounded outstanding reads, and counts in-order mismatches.
//
// state | meaning
// IDLE  | waiting for start
// WRITE | issuing pattern writes
// READ  | issuing reads, at most MAX_OUT in flight
// DRAIN | waiting for the remaining returns and their compares
// DONE  | one-cycle done pulse, pass valid
module sdram_bist_master #(
  parameter int          ADDR_W  = 25,
  parameter int          DATA_W  = 32,
  parameter int          N_WORDS = 1024,
  parameter int          MAX_OUT = 4,
  parameter logic [31:0] SEED    = 32'hA5A5_0001
) (
  input  logic                clock_50mhz,
  input  logic                pin_reset,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [15:0]         err_count_o,
  output logic [ADDR_W-1:0]   first_err_addr_o,
  output logic                proto_err_o,
  sdram_bist_master_if.master bus
);

  localparam int CNT_W = $clog2(N_WORDS + 1);
  localparam int OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  i_q, i_d;
  logic [CNT_W-1:0]  j_q, j_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [15:0]       err_q, err_d;
  logic [ADDR_W-1:0] first_q, first_d;
  logic              pass_q, pass_d;
  logic              proto_q, proto_d;
  logic              req_valid_c, req_write_c, issue, ret;

  function automatic logic [DATA_W-1:0] pat(input logic [CNT_W-1:0] idx);
    logic [15:0] lo;
    logic [31:0] w;
    lo = 16'(idx);
    w  = {~lo, lo} ^ SEED;
    return DATA_W'(w);
  endfunction

  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    base_d      = base_q;
    err_d       = err_q;
    first_d     = first_q;
    pass_d      = pass_q;
    proto_d     = proto_q;
    req_valid_c = 1'b0;
    req_write_c = 1'b0;
    issue       = 1'b0;
    ret         = bus.rd_valid && (out_q != '0);

    if (bus.rd_valid && (out_q == '0)) proto_d = 1'b1;

    // Mismatch result lands in err_count on the edge after the return strobe.
    if (ret) begin
      j_d = j_q + 1'b1;
      if (bus.rd_data != pat(j_q)) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (err_q == 16'd0) first_d = base_q + ADDR_W'(j_q);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_WRITE;
          base_d  = base_addr_i;
          err_d   = '0;
          first_d = '0;
          pass_d  = 1'b0;
          proto_d = 1'b0;
          i_d     = '0;
          j_d     = '0;
        end
      end
      S_WRITE: begin
        req_valid_c = 1'b1;
        req_write_c = 1'b1;
        if (bus.req_ready) begin
          if (i_q == CNT_W'(N_WORDS - 1)) begin
            i_d     = '0;
            state_d = S_READ;
          end else begin
            i_d = i_q + 1'b1;
          end
        end
      end
      S_READ: begin
        req_valid_c = (out_q < OUT_W'(MAX_OUT));
        if (req_valid_c && bus.req_ready) begin
          issue = 1'b1;
          i_d   = i_q + 1'b1;
          if (i_q == CNT_W'(N_WORDS - 1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if ((out_q == '0) && (j_q == CNT_W'(N_WORDS))) begin
          state_d = S_DONE;
          pass_d  = (err_q == 16'd0);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    out_d = out_q + OUT_W'(issue) - OUT_W'(ret);
  end

  always_ff @(posedge clock_50mhz) begin
    if (pin_reset) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      out_q   <= '0;
      base_q  <= '0;
      err_q   <= '0;
      first_q <= '0;
      pass_q  <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      out_q   <= out_d;
      base_q  <= base_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
      proto_q <= proto_d;
    end
  end

  assign busy_o           = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done_o           = (state_q == S_DONE);
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_err_addr_o = first_q;
  assign proto_err_o      = proto_q;

  // Address and data derive only from registers that move on a handshake, so they hold while stalled.
  assign bus.req_valid = req_valid_c;
  assign bus.req_write = req_write_c;
  assign bus.req_addr  = base_q + ADDR_W'(i_q);
  assign bus.req_wdata = pat(i_q);

endmodule
